alu_arbiter: RTL and testbench
==============================

# alu_arbiter

- Round-robin arbiter and sequencer sharing one registered 32-bit `alu` instance among `NUM_REQ` requesters.
- Accepts one operation at a time over a per-requester valid/ready request channel and drives the ALU operand/opcode inputs from registers.
- Waits out the ALU's one-cycle register stage, then returns the result on a single response channel tagged with the requester id.
- Sits between the instruction/issue units and the shared ALU.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the requester id.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid` in `NUM_REQ`: bit i = requester i has an operation.
- `req_ready` out `NUM_REQ`: bit i = requester i accepted this cycle; at most one bit high.
- `req_a` in `32*NUM_REQ`: operand a; slice i = `[32*i+31:32*i]`.
- `req_b` in `32*NUM_REQ`: operand b, same slicing.
- `req_opcode` in `4*NUM_REQ`: ALU opcode per requester.
- `req_carry` in `NUM_REQ`: carry/borrow-in per requester.
- `req_lock` in `NUM_REQ`: keep the grant for the next operation. Used only with `ALU_ARB_LOCK_EN`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_id` out `ID_W`: requester that issued the operation.
- `rsp_result` out 32: `alu_result` captured.
- `rsp_carry` out 1: `alu_carry_out` captured.
- `alu_a` out 32: registered drive to the ALU.
- `alu_b` out 32: registered drive to the ALU.
- `alu_opcode` out 4: registered drive to the ALU.
- `alu_carry_in` out 1: registered drive to the ALU.
- `alu_result` in 32: ALU registered outputs.
- `alu_carry_out` in 1: ALU registered output.

## Operation
- FSM states: IDLE, ISSUE, CAPT, RESP. Reset state is IDLE.
- **IDLE**
  - Combinational round-robin grant over `req_valid`.
  - Search starts at `last_id+1` and wraps modulo `NUM_REQ`.
  - `req_ready[g]=1` for the winner g only.
  - On accept: load `alu_a/b/opcode/carry_in` from slice g, store `cur_id=g`, set `last_id=g`, go ISSUE.
  - No valid request: stay in IDLE, `req_ready=0`.
- **ISSUE**: the ALU samples the driven operands at this edge. Go CAPT.
- **CAPT**: at this edge load `rsp_result<=alu_result`, `rsp_carry<=alu_carry_out`, `rsp_id<=cur_id`, `rsp_valid<=1`. Go RESP.
- **RESP**
  - Hold all `rsp_*` stable while `rsp_ready=0`.
  - On `rsp_valid&&rsp_ready`: clear `rsp_valid`, go IDLE.
  - No new request is accepted in the same cycle.
- `alu_*` outputs hold their last value between operations. They change only on accept.
- Opcodes pass through unmodified; all 16 codes are legal. The arbiter does not interpret carry semantics.
- Requests are not dropped. A non-granted requester keeps `req_valid` high and its operands stable until its `req_ready`.
- Reset values:
  - State IDLE.
  - `req_ready=0`.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`, `rsp_carry=0`.
  - `alu_a=0`, `alu_b=0`, `alu_opcode=0`, `alu_carry_in=0`.
  - `last_id=NUM_REQ-1`, so requester 0 has first priority.
- Reset mid-operation: any in-flight operation and pending response are discarded, with no response emitted. The first post-reset grant follows the reset priority.

## Timing
- Accept at edge E0. The ALU samples at E1. `rsp_valid` is high after E2.
- Accept-to-response latency is 2 cycles.
- Best-case throughput is one operation per 4 cycles: accept, ISSUE, CAPT, one RESP cycle with `rsp_ready=1`.
- `rsp_ready` held high: the next accept can occur the cycle after the response handshake.
- `req_ready` is a combinational function of state, `req_valid` and the priority pointer. It never depends on `rsp_ready`.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,`NUM_REQ-1`,0. Each requester waits at most `NUM_REQ-1` operations.

## Configuration
- Macro: `ALU_ARB_LOCK_EN`.
- **Defined**: if the accepted request had `req_lock[g]=1`, the next IDLE grant is restricted to g.
  - Other requesters are masked even if g's `req_valid` is low; the arbiter waits.
  - Purpose: chaining multi-word add/sub through `rsp_carry`.
  - The lock is released when g issues a request with `req_lock=0`.
  - Reset clears the lock.
- **Not defined**: `req_lock` is ignored and arbitration is pure round-robin. Port stays present for a stable interface.

## Test plan
- Reset, then requester 2 issues `a=32'h0000_0005`, `b=32'h0000_0003`, opcode `4'b0000` → `rsp_valid` two cycles after accept, `rsp_id=2`, `rsp_result=32'h0000_0008`.
- All 4 requesters valid continuously, each opcode `4'b0111` with `a=`id → grants and `rsp_id` sequence 0,1,2,3,0,1; `rsp_result` equals id each time.
- `rsp_ready` held low for 5 cycles during RESP → `rsp_*` stable, all `req_ready=0`. `rsp_ready=1` → response consumed, next accept in the following cycle.
- `rst` asserted in CAPT → next cycle `rsp_valid=0` and state IDLE, no response emitted. Requester 0 wins the first post-reset grant over requester 3.
- `ALU_ARB_LOCK_EN`: requester 1 issues opcode `4'b0000` with `a=b=32'hFFFF_FFFF` and `req_lock=1`, while requester 0 is also valid.
  - Next grant goes to 1 again: its opcode `4'b0001` request is accepted before requester 0.
  - Requester 1 releases with `req_lock=0`; requester 0 is then granted.
- Opcode sweep `4'b0000`..`4'b1111` from requester 3 with `a=32'h8000_0001`, `b=32'h0000_00F0`, `carry_in=1` → each `rsp_result` matches the ALU reference model for that opcode.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Round-robin arbiter and sequencer that shares one registered 32-bit ALU
// among NUM_REQ requesters. One operation is in flight at a time:
//   IDLE  -> accept one request (combinational round-robin grant)
//   ISSUE -> ALU samples the registered operands
//   CAPT  -> capture the ALU result into the response registers
//   RESP  -> hold the response until rsp_ready, then return to IDLE
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : per-requester request handshake (ready one-hot)
//   req_a/req_b              : 32-bit operand slices, slice i = [32*i+31:32*i]
//   req_opcode               : 4-bit opcode slices
//   req_carry                : carry/borrow-in per requester
//   req_lock                 : hold the grant for the next operation
//   rsp_valid/rsp_ready      : response handshake
//   rsp_id/rsp_result/rsp_carry : tagged response
//   alu_a/alu_b/alu_opcode/alu_carry_in : registered drive to the ALU
//   alu_result/alu_carry_out : ALU registered outputs
//
// Optional feature: define ALU_ARB_LOCK_EN to honour req_lock (grant stays
// with the locking requester until it issues an operation with req_lock=0).
// Without it req_lock is ignored but the port remains.

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  input  logic [4*NUM_REQ-1:0]   req_opcode,
  input  logic [NUM_REQ-1:0]     req_carry,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_result,
  output logic                   rsp_carry,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [3:0]             alu_opcode,
  output logic                   alu_carry_in,
  input  logic [31:0]            alu_result,
  input  logic                   alu_carry_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_CAPT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_id_q, last_id_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [31:0]       alu_a_q, alu_a_d;
  logic [31:0]       alu_b_q, alu_b_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic              alu_cin_q, alu_cin_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [31:0]       rsp_result_q, rsp_result_d;
  logic              rsp_carry_q, rsp_carry_d;

  logic [NUM_REQ-1:0] cand_s;
  logic               grant_found_s;
  logic [ID_W-1:0]    grant_id_s;
  logic               accept_s;

`ifdef ALU_ARB_LOCK_EN
  logic lock_q, lock_d;

  // Candidate mask: while locked, only the lock owner (last accepted) may win
  always_comb begin
    if (lock_q) begin
      cand_s = req_valid & ({{(NUM_REQ-1){1'b0}}, 1'b1} << last_id_q);
    end else begin
      cand_s = req_valid;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^req_lock;
  assign cand_s      = req_valid;
`endif

  // Round-robin search starting one past the last granted requester
  always_comb begin
    logic [ID_W-1:0] idx;
    idx           = '0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_id_q) + k) % NUM_REQ);
      if (!grant_found_s && cand_s[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = idx;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Ready only for the winner, only in IDLE; no handshake while reset is applied
  always_comb begin
    req_ready = '0;
    if ((state_q == S_IDLE) && grant_found_s && !rst) begin
      req_ready[grant_id_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  assign accept_s = |req_ready;

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) state_d = S_ISSUE;
        else          state_d = S_IDLE;
      end
      S_ISSUE: state_d = S_CAPT;
      S_CAPT:  state_d = S_RESP;
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = S_IDLE;
        else                          state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath next-state: operands load on accept, response loads in CAPT
  always_comb begin
    last_id_d    = last_id_q;
    cur_id_d     = cur_id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_cin_d    = alu_cin_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
`ifdef ALU_ARB_LOCK_EN
    lock_d       = lock_q;
`endif
    if (accept_s) begin
      alu_a_d   = req_a[32*int'(grant_id_s) +: 32];
      alu_b_d   = req_b[32*int'(grant_id_s) +: 32];
      alu_op_d  = req_opcode[4*int'(grant_id_s) +: 4];
      alu_cin_d = req_carry[grant_id_s];
      cur_id_d  = grant_id_s;
      last_id_d = grant_id_s;
`ifdef ALU_ARB_LOCK_EN
      lock_d    = req_lock[grant_id_s];
`endif
    end else if (state_q == S_CAPT) begin
      rsp_result_d = alu_result;
      rsp_carry_d  = alu_carry_out;
      rsp_id_d     = cur_id_q;
      rsp_valid_d  = 1'b1;
    end else if ((state_q == S_RESP) && rsp_valid_q && rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end else begin
      rsp_valid_d  = rsp_valid_q;
    end
  end

  // Datapath registers; last_id resets to NUM_REQ-1 so requester 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q    <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= '0;
      alu_a_q      <= 32'd0;
      alu_b_q      <= 32'd0;
      alu_op_q     <= 4'd0;
      alu_cin_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= 32'd0;
      rsp_carry_q  <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_q       <= 1'b0;
`endif
    end else begin
      last_id_q    <= last_id_d;
      cur_id_q     <= cur_id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_cin_q    <= alu_cin_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
`ifdef ALU_ARB_LOCK_EN
      lock_q       <= lock_d;
`endif
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_opcode   = alu_op_q;
  assign alu_carry_in = alu_cin_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_carry    = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed stimulus for alu_arbiter, with a
// behavioural ALU attached to the ALU ports and a transaction-level model of
// the arbiter (busy flag, age since accept, round-robin pointer).

module tb_alu_arbiter;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, req_carry, req_lock;
  logic [32*NR-1:0]  req_a, req_b;
  logic [4*NR-1:0]   req_opcode;
  logic              rsp_valid, rsp_ready, rsp_carry;
  logic [IDW-1:0]    rsp_id;
  logic [31:0]       rsp_result;
  logic [31:0]       alu_a, alu_b, alu_result;
  logic [3:0]        alu_opcode;
  logic              alu_carry_in, alu_carry_out;

  alu_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .req_carry(req_carry), .req_lock(req_lock),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  // Reference ALU: returns {carry_out, result}
  function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic cin);
    logic [32:0] r;
    case (op)
      4'h0: r = {1'b0, a} + {1'b0, b};
      4'h1: r = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      4'h2: r = {1'b0, a} - {1'b0, b};
      4'h3: r = {1'b0, a} - {1'b0, b} - {32'd0, cin};
      4'h4: r = {1'b0, a & b};
      4'h5: r = {1'b0, a | b};
      4'h6: r = {1'b0, a ^ b};
      4'h7: r = {1'b0, a};
      4'h8: r = {1'b0, b};
      4'h9: r = {1'b0, ~a};
      4'hA: r = {1'b0, a << b[4:0]};
      4'hB: r = {1'b0, a >> b[4:0]};
      4'hC: r = {1'b0, $unsigned($signed(a) >>> b[4:0])};
      4'hD: r = {32'd0, ($signed(a) < $signed(b))};
      4'hE: r = {32'd0, (a < b)};
      default: r = {1'b0, a + 32'd1};
    endcase
    return r;
  endfunction

  // The shared ALU: one register stage
  always_ff @(posedge clk) begin
    {alu_carry_out, alu_result} <= alu_ref(alu_a, alu_b, alu_opcode, alu_carry_in);
  end

  // Pending requests per requester (bench side)
  logic        p_v[NR];
  logic [31:0] p_a[NR], p_b[NR];
  logic [3:0]  p_op[NR];
  logic        p_c[NR], p_l[NR];
  logic        drv_rst, drv_rsp_ready;

  // Transaction-level model
  bit          m_busy, m_lock;
  int          m_age, m_last, m_id;
  logic [31:0] m_alu_a, m_alu_b, m_rsp_res;
  logic [3:0]  m_alu_op;
  logic        m_alu_c, m_rsp_c;
  int          m_rsp_id;
  int          grant_q[$], rsp_q[$];
  int          last_grant;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_lock = 1'b0; m_age = 0; m_last = NR - 1; m_id = 0;
    m_alu_a = 32'd0; m_alu_b = 32'd0; m_alu_op = 4'd0; m_alu_c = 1'b0;
    m_rsp_id = 0; m_rsp_res = 32'd0; m_rsp_c = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic c, input logic l);
    p_v[i] = 1'b1; p_a[i] = a; p_b[i] = b; p_op[i] = op; p_c[i] = c; p_l[i] = l;
  endtask

  task automatic drive_ports();
    rst = drv_rst;
    rsp_ready = drv_rsp_ready;
    for (int i = 0; i < NR; i++) begin
      req_valid[i]         = p_v[i];
      req_a[32*i +: 32]    = p_a[i];
      req_b[32*i +: 32]    = p_b[i];
      req_opcode[4*i +: 4] = p_op[i];
      req_carry[i]         = p_c[i];
      req_lock[i]          = p_l[i];
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model over the next posedge
  task automatic step();
    int win;
    logic [NR-1:0] exp_rdy;
    logic [32:0] r;
    @(negedge clk);
    drive_ports();
    #1;
    win = -1;
    if (!m_busy && !drv_rst) begin
      for (int k = 1; k <= NR; k++) begin
        int j;
        j = (m_last + k) % NR;
        if (win < 0 && p_v[j] && (!m_lock || j == m_last)) win = j;
      end
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    chk("rsp_valid", rsp_valid, (m_busy && m_age >= 2));
    chk("rsp_id", rsp_id, m_rsp_id);
    chk("rsp_result", rsp_result, m_rsp_res);
    chk("rsp_carry", rsp_carry, m_rsp_c);
    chk("alu_a", alu_a, m_alu_a);
    chk("alu_b", alu_b, m_alu_b);
    chk("alu_opcode", alu_opcode, m_alu_op);
    chk("alu_carry_in", alu_carry_in, m_alu_c);
    last_grant = -1;
    if (drv_rst) begin
      model_reset();
    end else if (win >= 0) begin
      m_busy = 1'b1; m_age = 0; m_id = win; m_last = win;
      m_alu_a = p_a[win]; m_alu_b = p_b[win]; m_alu_op = p_op[win]; m_alu_c = p_c[win];
`ifdef ALU_ARB_LOCK_EN
      m_lock = p_l[win];
`endif
      grant_q.push_back(win);
      last_grant = win;
      p_v[win] = 1'b0;
    end else if (m_busy) begin
      if (m_age == 1) begin
        r = alu_ref(m_alu_a, m_alu_b, m_alu_op, m_alu_c);
        m_rsp_res = r[31:0]; m_rsp_c = r[32]; m_rsp_id = m_id; m_age = 2;
      end else if (m_age >= 2) begin
        if (drv_rsp_ready) begin
          m_busy = 1'b0;
          rsp_q.push_back(m_id);
        end
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic wait_grant(input int id, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      step();
      if (last_grant == id) hit = 1'b1;
    end
    chk($sformatf("grant_to_%0d_in_time", id), hit, 1'b1);
  endtask

  task automatic wait_age(input int age, input int budget);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      step();
      if (m_busy && m_age == age) hit = 1'b1;
    end
    chk($sformatf("reach_age_%0d", age), hit, 1'b1);
  endtask

  // Run until nothing is pending or in flight; a lone lock owner is released
  task automatic drain(input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      bit any;
      any = 1'b0;
      for (int i = 0; i < NR; i++) any |= p_v[i];
      if (m_lock && !p_v[m_last]) begin
        set_req(m_last, $urandom, $urandom, 4'h7, 1'b0, 1'b0);
        any = 1'b1;
      end
      if (!any && !m_busy) done = 1'b1;
      else step();
    end
    chk("drain_in_time", done, 1'b1);
  endtask

  initial begin
    int base;
    for (int i = 0; i < NR; i++) begin
      p_v[i] = 1'b0; p_a[i] = 32'd0; p_b[i] = 32'd0; p_op[i] = 4'd0; p_c[i] = 1'b0; p_l[i] = 1'b0;
    end
    drv_rst = 1'b1; drv_rsp_ready = 1'b1;
    model_reset();
    drive_ports();
    repeat (3) step();
    drv_rst = 1'b0;
    step();

    // Single add from requester 2
    set_req(2, 32'h0000_0005, 32'h0000_0003, 4'b0000, 1'b0, 1'b0);
    drain(20);
    chk("t1_rsp_id", rsp_q[$], 2);
    chk("t1_result", rsp_result, 32'h0000_0008);

    // All requesters continuously valid: fairness sequence from reset priority
    drv_rst = 1'b1; step(); drv_rst = 1'b0;
    rsp_q.delete();
    for (int n = 0; n < 80 && rsp_q.size() < 6; n++) begin
      for (int i = 0; i < NR; i++) if (!p_v[i]) set_req(i, i, $urandom, 4'b0111, 1'b0, 1'b0);
      step();
    end
    chk("t2_rsp_count", rsp_q.size(), 6);
    for (int k = 0; k < 6 && k < rsp_q.size(); k++) chk($sformatf("t2_rsp_id_%0d", k), rsp_q[k], k % NR);
    drain(60);

    // Response backpressure: hold 5 cycles, then next accept right after handshake
    set_req(1, $urandom, $urandom, 4'b0010, 1'b0, 1'b0);
    drv_rsp_ready = 1'b0;
    wait_age(2, 20);
    set_req(0, $urandom, $urandom, 4'b0011, 1'b1, 1'b0);
    repeat (5) step();
    drv_rsp_ready = 1'b1;
    step();
    step();
    chk("t3_next_accept", last_grant, 0);
    drain(20);

    // Reset while in CAPT: response discarded, requester 0 wins over 3
    set_req(2, $urandom, $urandom, 4'b0110, 1'b0, 1'b0);
    wait_age(1, 20);
    base = rsp_q.size();
    set_req(0, $urandom, $urandom, 4'b0100, 1'b0, 1'b0);
    set_req(3, $urandom, $urandom, 4'b0101, 1'b0, 1'b0);
    drv_rst = 1'b1; step(); drv_rst = 1'b0;
    step();
    chk("t4_first_grant", last_grant, 0);
    drain(40);
    chk("t4_rsp_count", rsp_q.size(), base + 2);
    chk("t4_first_rsp", rsp_q[base], 0);

`ifdef ALU_ARB_LOCK_EN
    // Lock: requester 1 keeps the grant across a chained add
    drv_rst = 1'b1; step(); drv_rst = 1'b0;
    set_req(0, $urandom, $urandom, 4'b0111, 1'b0, 1'b0);
    drain(20);
    grant_q.delete();
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1'b1);
    set_req(0, $urandom, $urandom, 4'b1000, 1'b0, 1'b0);
    wait_grant(1, 10);
    repeat (8) step();
    chk("t5_masked", grant_q.size(), 1);
    chk("t5_carry", rsp_carry, 1'b1);
    set_req(1, 32'd0, 32'd0, 4'b0001, m_rsp_c, 1'b0);
    wait_grant(1, 10);
    wait_grant(0, 20);
    chk("t5_chain_result", m_rsp_res, 32'd1);
    chk("t5_grant_count", grant_q.size(), 3);
    drain(20);
`endif

    // Opcode sweep from requester 3
    for (int op = 0; op < 16; op++) begin
      set_req(3, 32'h8000_0001, 32'h0000_00F0, op[3:0], 1'b1, 1'b0);
      drain(20);
      chk($sformatf("t6_rsp_id_op%0d", op), rsp_q[$], 3);
    end

    // Random traffic with random backpressure
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (!p_v[i] && ($urandom % 3 == 0)) begin
          set_req(i, $urandom, $urandom, 4'($urandom), 1'($urandom), ($urandom % 8 == 0));
        end
      end
      drv_rsp_ready = ($urandom % 4 != 0);
      step();
    end
    drv_rsp_ready = 1'b1;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit in case a wait loop is broken
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
